array_result_drain: RTL and testbench
=====================================

// Module: array_result_drain
// PURPOSE
//  Downstream stage of the systolic PE array. Snapshots all BLOCK_SIZE*ARRAY_SIZE
//  32-bit partial-sum lanes leaving the array's last row on a capture pulse, then
//  serializes them one lane per beat over a valid/ready stream to the output
//  buffer / writeback logic. This frees the array to start the next tile while
//  the drain runs.
// PARAMETERS
//  BLOCK_SIZE  4  block width per cell; lanes per cell
//  DATA_WIDTH  8  operand width; each result lane is 4*DATA_WIDTH bits
//  ARRAY_SIZE  4  cells per array row
//  (localparam) LANES     = BLOCK_SIZE*ARRAY_SIZE
//  (localparam) IDX_WIDTH = $clog2(LANES)
// PORTS
//  Clk           in   1                    clock, rising edge
//  rst           in   1                    synchronous active-high reset
//  Array_Output  in   [4*DATA_WIDTH-1:0] x LANES   result lanes from the array
//  Capture       in   1                    pulse: snapshot Array_Output
//  Out_data      out  4*DATA_WIDTH         current lane value (signed)
//  Out_index     out  IDX_WIDTH            lane number of Out_data
//  Out_valid     out  1                    Out_data/Out_index/Out_last valid
//  Out_last      out  1                    high with the final lane (index LANES-1)
//  Out_ready     in   1                    consumer accepts the beat
//  Busy          out  1                    drain in progress (state DRAIN)
//  Overrun       out  1                    sticky: Capture lost while busy
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, idx=0, snapshot buffer=0, all outputs 0.
//    rst mid-drain aborts the drain immediately; remaining lanes are discarded.
//  - FSM IDLE: Out_valid=0. On Capture=1, all LANES are latched into the buffer,
//    idx<=0, and the FSM goes to DRAIN. Out_valid rises the next cycle (1-cycle latency).
//  - FSM DRAIN: Out_valid=1, Busy=1, Out_data=f(buf[idx]), Out_index=idx,
//    Out_last=(idx==LANES-1).
//  - Beat transfers when Out_valid && Out_ready. idx increments on each transfer.
//    On a transfer with idx==LANES-1, the FSM returns to IDLE and idx<=0.
//  - Out_ready=0 stalls the stream: data, index and last are held stable. The
//    consumer may not see a change until a transfer occurs.
//  - Capture during DRAIN is ignored, the buffer is unchanged, and Overrun<=1.
//    Exception: Capture in the same cycle as the last-lane transfer is accepted.
//    The buffer reloads, idx<=0, the FSM stays in DRAIN, and Overrun is not set
//    (back-to-back tiles, no bubble).
//  - Overrun clears only on rst.
//  - Out_valid, Out_index, Out_last and Busy are registered state. Out_data is
//    the registered buffer word passed through f(); it is not a combinational
//    path from Array_Output.
//  - Lanes are treated as two's-complement 4*DATA_WIDTH values. There is no
//    width change; f() is the identity unless the CONFIGURATION macro is set.
//  - Throughput: with Out_ready held high, one full tile takes LANES cycles.
// CONFIGURATION
//  DRAIN_RELU_EN defined:
//    f(x) = (x[4*DATA_WIDTH-1]) ? 0 : x   (ReLU on the output path).
//    The buffer still holds the raw value, so the output is applied, not stored.
//  DRAIN_RELU_EN undefined:
//    f(x) = x. No ReLU logic is synthesized.
// TESTING
//  1. rst=1 for 2 cycles with Capture=1 -> Out_valid=0, Busy=0, Overrun=0, Out_data=0.
//  2. Lanes k=0..15 loaded with value 100+k, Capture pulse, Out_ready=1 ->
//     Out_valid one cycle later. 16 beats, data 100..115, index 0..15, Out_last
//     only on beat 15. Busy=0 after the final beat.
//  3. Same load, Out_ready toggled 1,0,0,1 repeating -> all 16 values arrive in
//     order. Outputs are held stable on every ready=0 cycle. No beat is
//     duplicated or dropped.
//  4. Capture pulsed at beat 5 of a drain -> Overrun=1 until rst, and the
//     remaining beats still carry the original tile.
//  5. Second Capture in the same cycle as the beat-15 transfer, new lanes 200+k ->
//     the next cycle shows Out_valid=1, index 0, data 200. Overrun stays 0.
//  6. Lane 3 = 32'hFFFF_FF9C (-100) -> Out_data = FFFF_FF9C without
//     DRAIN_RELU_EN, and 0 with it defined. Lane 4 = 7 -> 7 in both builds.

Source files
------------

// File: rtl/array_result_drain_if.sv
// Result stream from the drain stage to the output buffer / writeback logic.
// One lane per beat, transferred when valid and ready are both high.
interface array_result_drain_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 4
) ();
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  index;
    logic              valid;
    logic              last;
    logic              ready;

    modport master (output data, output index, output valid, output last, input ready);
    modport slave  (input data, input index, input valid, input last, output ready);
endinterface

// File: rtl/array_result_drain.sv
// Snapshots all PE-array result lanes on a capture pulse and serializes them one
// lane per beat over a valid/ready stream. Optional macro: DRAIN_RELU_EN (ReLU on output).
module array_result_drain #(
    parameter int unsigned BLOCK_SIZE = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ARRAY_SIZE = 4
) (
    input  logic                                            i_clk,
    input  logic                                            i_rst,
    input  logic [BLOCK_SIZE*ARRAY_SIZE-1:0][4*DATA_WIDTH-1:0] i_array_output,
    input  logic                                            i_capture,
    output logic                                            o_busy,
    output logic                                            o_overrun,
    array_result_drain_if.master                            drain_if
);
    localparam int unsigned LANES     = BLOCK_SIZE * ARRAY_SIZE;
    localparam int unsigned IDX_WIDTH = $clog2(LANES);
    localparam int unsigned LANE_W    = 4 * DATA_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(LANES - 1);

    typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

    state_t                          r_state;
    logic [LANES-1:0][LANE_W-1:0]    r_buf;
    logic [IDX_WIDTH-1:0]            r_idx;
    logic                            r_valid;
    logic                            r_last;
    logic                            r_busy;
    logic                            r_overrun;

    logic [LANE_W-1:0]               w_lane;
    logic [LANE_W-1:0]               w_data;
    logic                            w_xfer;
    logic                            w_final_xfer;

    assign w_lane       = r_buf[r_idx];
    assign w_xfer       = r_valid && drain_if.ready;
    assign w_final_xfer = w_xfer && (r_idx == LAST_IDX);

    // Output transform works on the stored raw value; the buffer itself is never altered.
`ifdef DRAIN_RELU_EN
    assign w_data = w_lane[LANE_W-1] ? '0 : w_lane;
`else
    assign w_data = w_lane;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_buf     <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_capture) begin
                        r_buf   <= i_array_output;
                        r_idx   <= '0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_last  <= (LAST_IDX == '0);
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // A capture coinciding with the final transfer chains the next tile with no bubble.
                    if (w_final_xfer) begin
                        r_idx <= '0;
                        if (i_capture) begin
                            r_buf  <= i_array_output;
                            r_last <= (LAST_IDX == '0);
                        end else begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else if (w_xfer) begin
                        r_idx  <= r_idx + IDX_WIDTH'(1);
                        r_last <= ((r_idx + IDX_WIDTH'(1)) == LAST_IDX);
                    end
                    if (i_capture && !w_final_xfer) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign drain_if.data  = w_data;
    assign drain_if.index = r_idx;
    assign drain_if.valid = r_valid;
    assign drain_if.last  = r_last;
    assign o_busy         = r_busy;
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_array_result_drain.sv
// Directed self-checking bench for array_result_drain: reset, full drains, stalls,
// overrun, back-to-back tiles and signed lane handling.
module tb_array_result_drain;
    localparam int unsigned LANES = 16;

    logic                   clk;
    logic                   rst;
    logic                   capture;
    logic [LANES-1:0][31:0] arr;
    logic                   busy;
    logic                   overrun;
    int                     checks;
    int                     failures;

    array_result_drain_if #(.DATA_W(32), .IDX_W(4)) u_if ();

    array_result_drain #(.BLOCK_SIZE(4), .DATA_WIDTH(8), .ARRAY_SIZE(4)) u_dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_array_output (arr),
        .i_capture      (capture),
        .o_busy         (busy),
        .o_overrun      (overrun),
        .drain_if       (u_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_tile(input int base);
        for (int k = 0; k < LANES; k++) arr[k] = 32'(base + k);
    endtask

    // Checks one beat of a tile whose lane k holds base+k, with ready high.
    task automatic check_beat(input string tag, input int base, input int b);
        check({tag, "_valid"}, 32'(u_if.valid), 32'd1);
        check({tag, "_data"},  u_if.data, 32'(base + b));
        check({tag, "_index"}, 32'(u_if.index), 32'(b));
        check({tag, "_last"},  32'(u_if.last), 32'(b == LANES - 1));
    endtask

    initial begin
        int b;
        int c;
        logic [31:0] exp3;
        checks   = 0;
        failures = 0;

        // Reset held with capture asserted
        rst = 1'b1; capture = 1'b1; arr = '0; u_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid",   32'(u_if.valid), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_data",    u_if.data, 32'd0);
        rst = 1'b0; capture = 1'b0;

        // Full drain with ready held high
        load_tile(100); capture = 1'b1; u_if.ready = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            check_beat("full", 100, i);
            @(negedge clk);
        end
        check("full_done_valid", 32'(u_if.valid), 32'd0);
        check("full_done_busy",  32'(busy), 32'd0);

        // Stalling consumer: ready pattern 1,0,0,1
        load_tile(100); capture = 1'b1; u_if.ready = 1'b0;
        @(negedge clk);
        capture = 1'b0;
        b = 0; c = 0;
        while (b < LANES && c < 200) begin
            u_if.ready = (c % 4 == 0) || (c % 4 == 3);
            check_beat("stall", 100, b);
            if (u_if.ready) b++;
            c++;
            @(negedge clk);
        end
        check("stall_count", 32'(b), 32'(LANES));
        check("stall_done_valid", 32'(u_if.valid), 32'd0);

        // Capture mid-drain is lost and flagged; buffer keeps the original tile
        load_tile(100); capture = 1'b1; u_if.ready = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (i == 5) begin
                load_tile(300);
                capture = 1'b1;
            end else begin
                capture = 1'b0;
            end
            check_beat("ovr", 100, i);
            if (i > 5) check("ovr_flag", 32'(overrun), 32'd1);
            @(negedge clk);
        end
        check("ovr_idle_valid", 32'(u_if.valid), 32'd0);
        repeat (3) @(negedge clk);
        check("ovr_sticky", 32'(overrun), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Back-to-back tile: capture coincides with last-lane transfer
        load_tile(100); capture = 1'b1; u_if.ready = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            check_beat("b2b_a", 100, i);
            if (i == LANES - 1) begin
                load_tile(200);
                capture = 1'b1;
            end
            @(negedge clk);
        end
        capture = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        for (int i = 0; i < LANES; i++) begin
            check_beat("b2b_b", 200, i);
            @(negedge clk);
        end
        check("b2b_overrun", 32'(overrun), 32'd0);
        check("b2b_done_valid", 32'(u_if.valid), 32'd0);

        // Reset mid-drain aborts immediately
        load_tile(100); capture = 1'b1; u_if.ready = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_pre_index", 32'(u_if.index), 32'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", 32'(u_if.valid), 32'd0);
        check("abort_busy",  32'(busy), 32'd0);
        check("abort_index", 32'(u_if.index), 32'd0);
        check("abort_data",  u_if.data, 32'd0);

        // Signed lanes: negative value is passed or clamped depending on build
        load_tile(0);
        arr[3] = 32'hFFFF_FF9C;
        arr[4] = 32'd7;
`ifdef DRAIN_RELU_EN
        exp3 = 32'd0;
`else
        exp3 = 32'hFFFF_FF9C;
`endif
        capture = 1'b1; u_if.ready = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            check("sgn_index", 32'(u_if.index), 32'(i));
            if (i == 3) check("sgn_lane3", u_if.data, exp3);
            if (i == 4) check("sgn_lane4", u_if.data, 32'd7);
            @(negedge clk);
        end
        check("sgn_done_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
